arb_seq_checker: RTL and testbench
==================================

Name: arb_seq_checker

Overview:
- Downstream monitor for the 3-bit arbitrary-sequence counter output.
- Consumes one 3-bit code per valid cycle and checks it against the fixed repeating sequence 0,1,2,3,6,5,7.
- Reports lock status, per-sample mismatch pulses, a saturating error count and a completed-sequence count.
- Used in bring-up and BIST to qualify the counter stage.

Parameters:
- LOCK_LEN, 7: consecutive correct samples required to declare lock (1..15).
- UNLOCK_LEN, 3: consecutive mismatches while locked that drop lock (1..15).
- ERR_W, 8: err_count width; saturates at all-ones.
- CNT_W, 16: seq_count width; saturates at all-ones.
- TIMEOUT, 64: idle cycles before lock is dropped. Used only with the optional feature.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: in_code is a valid sample this cycle.
- in_code, input, 3: code from the counter stage.
- locked, output, 1: checker is locked to the sequence.
- mismatch, output, 1: one-cycle pulse, valid sample disagreed with expected_code while locked.
- expected_code, output, 3: code expected on the next valid sample.
- err_count, output, ERR_W: mismatches counted while locked.
- seq_count, output, CNT_W: full 7-code sequences matched while locked.

Behaviour:
- Reset is synchronous and active-high (reset), clocked on clock. Reset values:
  - state = SEARCH; idx = 0; run = 0; miss = 0.
  - locked = 0; mismatch = 0; err_count = 0; seq_count = 0.
  - expected_code = 0.
- Reset mid-operation overrides everything in that cycle.
- expected_code is always SEQ[idx]. All outputs are registered, so each sample's response appears 1 cycle after it.
- in_valid = 0: no state or counter change; mismatch = 0 on the next cycle.
- State SEARCH:
  - Valid sample with code 0: idx = 1, run = 1, go to VERIFY.
  - Any other valid code: ignored.
- State VERIFY:
  - Valid sample == SEQ[idx]: idx advances (6 wraps to 0), run increments.
  - When run reaches LOCK_LEN: go to LOCKED, locked = 1, miss = 0.
  - Wrong sample with code 0: restart, idx = 1, run = 1, stay in VERIFY.
  - Wrong sample with any other code: go to SEARCH, idx = 0.
  - No counting and no mismatch pulses in this state.
- State LOCKED:
  - Correct sample: idx advances, miss = 0.
  - Correct sample with idx == 6 (code 7): seq_count increments, saturating.
  - Wrong sample: mismatch pulses for 1 cycle, err_count increments (saturating), miss increments.
  - idx still advances on a wrong sample (flywheel), so a single corrupted code costs exactly one error.
  - When miss reaches UNLOCK_LEN: go to SEARCH, locked = 0, idx = 0, run = 0.
  - The final mismatch that drops lock is still pulsed and counted.
- Code 4 never appears in SEQ and always mismatches.
- Saturated counters hold at all-ones until reset.

Optional Feature:
- Macro: ARB_SEQ_CHK_TIMEOUT_EN.
- Defined: a watchdog counter increments each LOCKED cycle with in_valid = 0 and clears on any valid sample. When it reaches TIMEOUT: go to SEARCH, locked = 0, idx = 0. err_count is not incremented.
- Undefined: no watchdog logic; lock is held indefinitely without valid samples; the TIMEOUT parameter is unused.

Decomposition:
- Shared package arb_seq_pkg holds:
  - SEQ_LEN = 7 and the SEQ[0..6] code constants.
  - The state enum {SEARCH, VERIFY, LOCKED}.
  - A next-index function (6 -> 0).
- The counter stage reuses the same constants.
- One sub-module, arb_seq_sat_counter: a parameterised-width saturating incrementer with enable and synchronous clear. Instantiated for err_count and seq_count.

Test Plan:
- Ideal stream: reset, then 0,1,2,3,6,5,7 repeated with in_valid = 1.
  - locked = 1 one cycle after the 7th sample.
  - After 21 samples: seq_count = 2, err_count = 0, mismatch never asserted.
- Single corruption: while locked, replace one 6 with 4.
  - One mismatch pulse, err_count = 1, locked stays 1.
  - The next sample (5) matches; seq_count continues advancing.
- Loss of lock (UNLOCK_LEN = 3): feed three consecutive wrong codes while locked.
  - err_count = 3, locked = 0 after the third.
  - Re-lock occurs 7 samples after the next 0.
- Acquisition edge cases:
  - Stream 5,7,0,1,0,1,2,3,6,5,7 stays in VERIFY through the restart at the second 0.
  - locked asserts after the final 7.
  - Gaps with in_valid = 0 inserted mid-stream do not disturb the result.
- Saturation and reset (ERR_W = 2):
  - Five mismatches in locked state: err_count = 3 and holds.
  - Assert reset mid-sequence: all outputs 0 on the next cycle.
- ARB_SEQ_CHK_TIMEOUT_EN with TIMEOUT = 64, while locked:
  - in_valid low for 63 cycles: still locked.
  - in_valid low for 64 cycles: locked = 0, err_count unchanged.

Source files
------------

// File: rtl/arb_seq_pkg.sv
// Shared constants for the arbitrary-sequence counter and its checker: the repeating
// code sequence 0,1,2,3,6,5,7, the checker state encoding and index wrap helper.
package arb_seq_pkg;

    localparam int SEQ_LEN = 7;

    localparam logic [2:0] SEQ_0 = 3'd0;
    localparam logic [2:0] SEQ_1 = 3'd1;
    localparam logic [2:0] SEQ_2 = 3'd2;
    localparam logic [2:0] SEQ_3 = 3'd3;
    localparam logic [2:0] SEQ_4 = 3'd6;
    localparam logic [2:0] SEQ_5 = 3'd5;
    localparam logic [2:0] SEQ_6 = 3'd7;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [2:0] seq_at(input logic [2:0] idx);
        case (idx)
            3'd0:    return SEQ_0;
            3'd1:    return SEQ_1;
            3'd2:    return SEQ_2;
            3'd3:    return SEQ_3;
            3'd4:    return SEQ_4;
            3'd5:    return SEQ_5;
            3'd6:    return SEQ_6;
            default: return SEQ_0;
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == 3'(SEQ_LEN - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/arb_seq_sat_counter.sv
// Saturating up-counter of width W with enable and synchronous clear.
// One cycle from enable to updated count; holds at all-ones until reset or clear.
module arb_seq_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/arb_seq_checker.sv
// Lock/verify monitor for the 3-bit arbitrary-sequence counter; all outputs one cycle after the sample.
// Optional idle watchdog that drops lock is built only with ARB_SEQ_CHK_TIMEOUT_EN defined.
module arb_seq_checker
    import arb_seq_pkg::*;
#(
    parameter int LOCK_LEN   = 7,
    parameter int UNLOCK_LEN = 3,
    parameter int ERR_W      = 8,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_code,
    output logic             locked,
    output logic             mismatch,
    output logic [2:0]       expected_code,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] seq_count
);

    localparam logic [3:0] LOCK_L   = 4'(LOCK_LEN);
    localparam logic [3:0] UNLOCK_L = 4'(UNLOCK_LEN);

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [3:0] run, run_n;
    logic [3:0] miss, miss_n;
    logic       mm_n, err_inc, seq_inc, hit;

    assign hit = (in_code == seq_at(idx));

`ifdef ARB_SEQ_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd, wd_n;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        run_n   = run;
        miss_n  = miss;
        mm_n    = 1'b0;
        err_inc = 1'b0;
        seq_inc = 1'b0;
        if (in_valid) begin
            case (state)
                SEARCH: begin
                    if (in_code == SEQ_0) begin
                        idx_n   = 3'd1;
                        run_n   = 4'd1;
                        miss_n  = 4'd0;
                        state_n = (LOCK_L == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        idx_n = next_idx(idx);
                        run_n = run + 4'd1;
                        if (run_n == LOCK_L) begin
                            state_n = LOCKED;
                            miss_n  = 4'd0;
                        end
                    end else if (in_code == SEQ_0) begin
                        // A stray 0 is treated as a fresh sequence start.
                        idx_n = 3'd1;
                        run_n = 4'd1;
                    end else begin
                        state_n = SEARCH;
                        idx_n   = 3'd0;
                        run_n   = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: index advances whether or not the sample matched.
                    idx_n = next_idx(idx);
                    if (hit) begin
                        miss_n  = 4'd0;
                        seq_inc = (idx == 3'(SEQ_LEN - 1));
                    end else begin
                        mm_n    = 1'b1;
                        err_inc = 1'b1;
                        miss_n  = miss + 4'd1;
                        if (miss_n == UNLOCK_L) begin
                            state_n = SEARCH;
                            idx_n   = 3'd0;
                            run_n   = 4'd0;
                            miss_n  = 4'd0;
                        end
                    end
                end
                default: begin
                    state_n = SEARCH;
                    idx_n   = 3'd0;
                    run_n   = 4'd0;
                    miss_n  = 4'd0;
                end
            endcase
        end
`ifdef ARB_SEQ_CHK_TIMEOUT_EN
        wd_n = '0;
        if (!in_valid && (state == LOCKED)) begin
            wd_n = wd + 1'b1;
            if (wd_n == WD_W'(TIMEOUT)) begin
                state_n = SEARCH;
                idx_n   = 3'd0;
                run_n   = 4'd0;
                miss_n  = 4'd0;
                wd_n    = '0;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= SEARCH;
            idx           <= 3'd0;
            run           <= 4'd0;
            miss          <= 4'd0;
            locked        <= 1'b0;
            mismatch      <= 1'b0;
            expected_code <= 3'd0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            run           <= run_n;
            miss          <= miss_n;
            locked        <= (state_n == LOCKED);
            mismatch      <= mm_n;
            expected_code <= seq_at(idx_n);
        end
    end

`ifdef ARB_SEQ_CHK_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wd <= '0;
        end else begin
            wd <= wd_n;
        end
    end
`endif

    arb_seq_sat_counter #(.W(ERR_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (err_inc),
        .count (err_count)
    );

    arb_seq_sat_counter #(.W(CNT_W)) u_seq_cnt (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (seq_inc),
        .count (seq_count)
    );

endmodule

// File: tb/tb_arb_seq_checker.sv
// Bench for arb_seq_checker with a 2-bit error counter; an abstract model tracks the
// expected outputs from the sequence rules. Watchdog tests follow ARB_SEQ_CHK_TIMEOUT_EN.
module tb_arb_seq_checker;

    localparam int LOCK_LEN   = 7;
    localparam int UNLOCK_LEN = 3;
    localparam int ERR_W      = 2;
    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 64;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [2:0]       in_code = 3'd0;
    logic             locked, mismatch;
    logic [2:0]       expected_code;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] seq_count;

    int checks = 0;
    int failures = 0;

    int SEQ [7] = '{0, 1, 2, 3, 6, 5, 7};

    // Abstract model: mode 0 = hunting for a 0, 1 = confirming, 2 = locked.
    int m_mode, m_pos, m_good, m_bad, m_err, m_seq, m_idle;
    bit m_mm;

    arb_seq_checker #(
        .LOCK_LEN(LOCK_LEN), .UNLOCK_LEN(UNLOCK_LEN), .ERR_W(ERR_W),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_code(in_code),
        .locked(locked), .mismatch(mismatch), .expected_code(expected_code),
        .err_count(err_count), .seq_count(seq_count)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0;
        m_err = 0; m_seq = 0; m_idle = 0; m_mm = 0;
    endtask

    task automatic model_step(input bit v, input int c);
        m_mm = 0;
        if (v) begin
            m_idle = 0;
            if (m_mode == 0) begin
                if (c == 0) begin
                    m_pos = 1; m_good = 1; m_bad = 0;
                    m_mode = (m_good >= LOCK_LEN) ? 2 : 1;
                end
            end else if (m_mode == 1) begin
                if (c == SEQ[m_pos]) begin
                    m_pos = (m_pos + 1) % 7; m_good++;
                    if (m_good >= LOCK_LEN) begin m_mode = 2; m_bad = 0; end
                end else if (c == 0) begin
                    m_pos = 1; m_good = 1;
                end else begin
                    m_mode = 0; m_pos = 0; m_good = 0;
                end
            end else begin
                if (c == SEQ[m_pos]) begin
                    if (m_pos == 6 && m_seq < CNT_MAX) m_seq++;
                    m_bad = 0;
                end else begin
                    m_mm = 1; m_bad++;
                    if (m_err < ERR_MAX) m_err++;
                end
                m_pos = (m_pos + 1) % 7;
                if (m_bad >= UNLOCK_LEN) begin
                    m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0;
                end
            end
        end else if (m_mode == 2) begin
`ifdef ARB_SEQ_CHK_TIMEOUT_EN
            m_idle++;
            if (m_idle >= TIMEOUT) begin
                m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0; m_idle = 0;
            end
`endif
        end
    endtask

    task automatic drive(input bit v, input int c);
        in_valid = v;
        in_code  = 3'(c);
        @(posedge clock);
        model_step(v, c);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clock);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        do_reset();
        checks++;
        if ({locked, mismatch, expected_code, err_count, seq_count} !== '0) begin
            failures++;
            $display("FAIL reset_state: got l=%0b m=%0b e=%0d err=%0d seq=%0d want all 0",
                     locked, mismatch, expected_code, err_count, seq_count);
        end
    endtask

    task automatic test_ideal();
        bit mm_seen = 0;
        for (int i = 1; i <= 21; i++) begin
            drive(1, SEQ[(i - 1) % 7]);
            if (mismatch) mm_seen = 1;
            if (i == 6) begin
                checks++;
                if (locked !== 1'b0) begin failures++; $display("FAIL ideal_prelock: locked=%0b want 0", locked); end
            end
            if (i == 7) begin
                checks++;
                if (locked !== 1'b1) begin failures++; $display("FAIL ideal_lock: locked=%0b want 1", locked); end
            end
            checks++;
            if (expected_code !== 3'(SEQ[i % 7])) begin
                failures++; $display("FAIL ideal_expected: got %0d want %0d", expected_code, SEQ[i % 7]);
            end
        end
        checks++;
        if (seq_count !== 16'd2 || err_count !== 2'd0 || mm_seen) begin
            failures++;
            $display("FAIL ideal_counts: seq=%0d err=%0d mm_seen=%0b want 2 0 0", seq_count, err_count, mm_seen);
        end
    endtask

    task automatic test_corrupt();
        int codes [7] = '{0, 1, 2, 3, 4, 5, 7};
        for (int i = 0; i < 7; i++) begin
            drive(1, codes[i]);
            if (i == 4) begin
                checks++;
                if ({mismatch, err_count, locked} !== {1'b1, 2'd1, 1'b1}) begin
                    failures++;
                    $display("FAIL corrupt_pulse: mm=%0b err=%0d locked=%0b want 1 1 1", mismatch, err_count, locked);
                end
            end
            if (i == 5) begin
                checks++;
                if (mismatch !== 1'b0) begin failures++; $display("FAIL corrupt_recover: mm=%0b want 0", mismatch); end
            end
        end
        checks++;
        if (seq_count !== 16'd3 || locked !== 1'b1) begin
            failures++; $display("FAIL corrupt_seq: seq=%0d locked=%0b want 3 1", seq_count, locked);
        end
    endtask

    task automatic test_unlock();
        do_reset();
        for (int i = 0; i < 7; i++) drive(1, SEQ[i]);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4);
            if (i < 2) begin
                checks++;
                if (locked !== 1'b1) begin failures++; $display("FAIL unlock_early: locked=%0b want 1 after %0d misses", locked, i + 1); end
            end
        end
        checks++;
        if ({locked, err_count, mismatch} !== {1'b0, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL unlock_drop: locked=%0b err=%0d mm=%0b want 0 3 1", locked, err_count, mismatch);
        end
        for (int i = 0; i < 7; i++) begin
            drive(1, SEQ[i]);
            checks++;
            if (locked !== (i == 6)) begin
                failures++; $display("FAIL relock: sample %0d locked=%0b want %0b", i, locked, i == 6);
            end
        end
    endtask

    task automatic test_acquire();
        int codes [11] = '{5, 7, 0, 1, 0, 1, 2, 3, 6, 5, 7};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                int gaps = $urandom_range(1, 3);
                for (int g = 0; g < gaps; g++) drive(0, $urandom_range(0, 7));
            end
            drive(1, codes[i]);
            checks++;
            if (locked !== (i == 10)) begin
                failures++; $display("FAIL acquire: sample %0d locked=%0b want %0b", i, locked, i == 10);
            end
        end
        checks++;
        if (expected_code !== 3'd0) begin failures++; $display("FAIL acquire_expected: got %0d want 0", expected_code); end
    endtask

    task automatic test_saturation();
        int codes [10] = '{4, 1, 4, 3, 4, 5, 4, 0, 4, 2};
        do_reset();
        for (int i = 0; i < 7; i++) drive(1, SEQ[i]);
        for (int i = 0; i < 10; i++) drive(1, codes[i]);
        checks++;
        if ({err_count, locked} !== {2'd3, 1'b1}) begin
            failures++; $display("FAIL saturate: err=%0d locked=%0b want 3 1", err_count, locked);
        end
        reset = 1'b1; in_valid = 1'b1; in_code = 3'd3;
        @(posedge clock);
        model_reset();
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if ({locked, mismatch, expected_code, err_count, seq_count} !== '0) begin
            failures++;
            $display("FAIL midreset: l=%0b m=%0b e=%0d err=%0d seq=%0d want all 0",
                     locked, mismatch, expected_code, err_count, seq_count);
        end
    endtask

    task automatic test_random();
        int g = 0;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 15) drive(0, $urandom_range(0, 7));
            else if (r < 24) begin drive(1, $urandom_range(0, 7)); g = (g + 1) % 7; end
            else if (r < 26) begin g = $urandom_range(0, 6); drive(1, SEQ[g]); g = (g + 1) % 7; end
            else begin drive(1, SEQ[g]); g = (g + 1) % 7; end
            checks++;
            if ({locked, mismatch, expected_code, err_count, seq_count} !==
                {m_mode == 2, m_mm, 3'(SEQ[m_pos]), ERR_W'(m_err), CNT_W'(m_seq)}) begin
                failures++;
                $display("FAIL random[%0d]: got l=%0b m=%0b e=%0d err=%0d seq=%0d want l=%0b m=%0b e=%0d err=%0d seq=%0d",
                         n, locked, mismatch, expected_code, err_count, seq_count,
                         m_mode == 2, m_mm, SEQ[m_pos], m_err, m_seq);
            end
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 7; i++) drive(1, SEQ[i]);
        drive(1, 4);
`ifdef ARB_SEQ_CHK_TIMEOUT_EN
        for (int i = 0; i < 63; i++) drive(0, 0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL idle_63: locked=%0b want 1", locked); end
        drive(0, 0);
        checks++;
        if ({locked, err_count} !== {1'b0, 2'd1}) begin
            failures++; $display("FAIL idle_64: locked=%0b err=%0d want 0 1", locked, err_count);
        end
`else
        for (int i = 0; i < 100; i++) drive(0, 0);
        checks++;
        if ({locked, err_count} !== {1'b1, 2'd1}) begin
            failures++; $display("FAIL idle_hold: locked=%0b err=%0d want 1 1", locked, err_count);
        end
`endif
        checks++;
        if ({locked, expected_code} !== {m_mode == 2, 3'(SEQ[m_pos])}) begin
            failures++; $display("FAIL idle_model: locked=%0b e=%0d want %0b %0d", locked, expected_code, m_mode == 2, SEQ[m_pos]);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ideal();
        test_corrupt();
        test_unlock();
        test_acquire();
        test_saturation();
        test_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
